// File: rtl/gelu_lut_loader_if.sv
// ---------------------------------------------------------------------------
// gelu_lut_loader_if
// Bundles the host entry stream and the shared LUT write bus of the GELU/exp
// datapath.
//   load_start            host -> loader  one-cycle pulse, start a full table load
//   in_valid/in_ready     host <-> loader entry handshake
//   in_log2/in_exp2       host -> loader  paired LUT entry
//   lut_wr_en             loader -> LUTs  write strobe
//   log2_lut_data_in      loader -> LUTs  log2 entry driven with the strobe
//   exp2_lut_data_in      loader -> LUTs  exp2 entry driven with the strobe
//   lut_busy/lut_loaded   loader -> top   load status
//   lut_checksum          loader -> top   mod-2^FLOAT_LEN sum of the loaded entries
// Modports:
//   master  the loader, which masters the LUT write bus
//   slave   the host plus the LUT receivers / status consumers
// ---------------------------------------------------------------------------
interface gelu_lut_loader_if #(
  parameter int FLOAT_LEN = 16,
  parameter int MANT_LEN  = 10
);
  logic                 load_start;
  logic                 in_valid;
  logic                 in_ready;
  logic [MANT_LEN-1:0]  in_log2;
  logic [FLOAT_LEN-1:0] in_exp2;
  logic                 lut_wr_en;
  logic [MANT_LEN-1:0]  log2_lut_data_in;
  logic [FLOAT_LEN-1:0] exp2_lut_data_in;
  logic                 lut_busy;
  logic                 lut_loaded;
  logic [FLOAT_LEN-1:0] lut_checksum;

  modport master (
    input  load_start, in_valid, in_log2, in_exp2,
    output in_ready, lut_wr_en, log2_lut_data_in, exp2_lut_data_in,
           lut_busy, lut_loaded, lut_checksum
  );

  modport slave (
    output load_start, in_valid, in_log2, in_exp2,
    input  in_ready, lut_wr_en, log2_lut_data_in, exp2_lut_data_in,
           lut_busy, lut_loaded, lut_checksum
  );
endinterface

// File: rtl/gelu_lut_loader.sv
// ---------------------------------------------------------------------------
// gelu_lut_loader
// Write-side master for the shared LUT-load bus of the GELU/exp datapath.
// Accepts paired (log2, exp2) entries from the host over a valid/ready stream
// and broadcasts exactly LUT_DEPTH write strobes per load, so every receiver's
// own write pointer wraps back to 0 at the end of the load.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   lut_bus gelu_lut_loader_if.master (host stream in, LUT write bus and status out)
// ---------------------------------------------------------------------------
module gelu_lut_loader #(
  parameter int FLOAT_LEN = 16,
  parameter int MANT_LEN  = 10,
  parameter int LUT_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gelu_lut_loader_if.master    lut_bus
);

  localparam int CNT_W = $clog2(LUT_DEPTH);
  localparam int PAD_W = FLOAT_LEN - MANT_LEN;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LUT_DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [FLOAT_LEN-1:0] r_sum;
  logic                 r_wr_en;
  logic [MANT_LEN-1:0]  r_log2;
  logic [FLOAT_LEN-1:0] r_exp2;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_start;
  logic                 w_last;

  // Handshake and start decode; load_start is only honoured outside LOAD so a
  // running load can never be restarted and receiver pointers stay aligned.
  always_comb begin
    w_in_ready = (r_state == ST_LOAD);
    w_accept   = lut_bus.in_valid & w_in_ready;
    w_start    = lut_bus.load_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    w_last     = w_accept & (r_cnt == LAST_IDX);
  end

  // Next-state decode for the load sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (lut_bus.load_start) w_state_nxt = ST_LOAD;
        else                    w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_LOAD;
      end
      ST_DONE: begin
        if (lut_bus.load_start) w_state_nxt = ST_LOAD;
        else                    w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, entry counter, checksum and the registered write bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_wr_en <= 1'b0;
      r_log2  <= '0;
      r_exp2  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_log2 <= lut_bus.in_log2;
        r_exp2 <= lut_bus.in_exp2;
      end
      // The counter wraps naturally to 0 on the last entry (LUT_DEPTH is 2^CNT_W).
      if (w_start) begin
        r_cnt <= '0;
        r_sum <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_sum <= r_sum + {{PAD_W{1'b0}}, lut_bus.in_log2} + lut_bus.in_exp2;
      end
    end
  end

  // Status is decoded from the state register, so lut_loaded falls in the
  // same cycle lut_busy rises, and both track an async reset immediately.
  assign lut_bus.in_ready         = w_in_ready;
  assign lut_bus.lut_wr_en        = r_wr_en;
  assign lut_bus.log2_lut_data_in = r_log2;
  assign lut_bus.exp2_lut_data_in = r_exp2;
  assign lut_bus.lut_busy         = (r_state == ST_LOAD);
  assign lut_bus.lut_loaded       = (r_state == ST_DONE);
  assign lut_bus.lut_checksum     = r_sum;

endmodule
